// File: rtl/q_sys_dig_error_monitor_if.sv
// -----------------------------------------------------------------------------
// q_sys_dig_error_monitor_if
// Avalon-MM slave bus bundle for the digit-error monitor.
//   address    : register word address (3 bits)
//   chipselect : slave select
//   write_n    : write strobe, active low
//   writedata  : write data (32 bits)
//   readdata   : registered read data (32 bits), driven by the slave
// -----------------------------------------------------------------------------
interface q_sys_dig_error_monitor_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/q_sys_dig_error_monitor.sv
// -----------------------------------------------------------------------------
// q_sys_dig_error_monitor
// Turns the raw digit-error vector of the error-correcting datapath into
// host-visible events: synchronized live view, sticky rising-edge bits (W1C),
// a saturating event counter, first-event digit index and a maskable irq.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata with 1-cycle read latency)
//   in_port  : raw digit-error vector, asynchronous to clk
//   irq      : level interrupt, |(EDGE & MASK), registered
//
// Register map: 0 LIVE, 1 EDGE (W1C), 2 MASK, 3 COUNT (write clears),
//               4 FIRST (write re-arms; bit31 valid, [4:0] index), 5 CTRL
//               (bit0 enable), 6/7 read as zero.
// -----------------------------------------------------------------------------
module q_sys_dig_error_monitor #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    q_sys_dig_error_monitor_if.slave        bus,
    input  logic [WIDTH-1:0]                in_port,
    output logic                            irq
);

    typedef enum logic {
        ARMED    = 1'b0,
        CAPTURED = 1'b1
    } first_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] s1, s2, s3;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_q, edge_clr;
    logic [WIDTH-1:0] mask_q;
    logic             enable_q;
    logic [CNT_W-1:0] count_q, count_d;
    first_state_t     state_q, state_d;
    logic [4:0]       index_q, index_d, low_idx;
    logic [31:0]      rd_mux;

    logic wr;
    logic wr_edge, wr_mask, wr_count, wr_first, wr_ctrl;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_edge  = wr && (bus.address == 3'd1);
    assign wr_mask  = wr && (bus.address == 3'd2);
    assign wr_count = wr && (bus.address == 3'd3);
    assign wr_first = wr && (bus.address == 3'd4);
    assign wr_ctrl  = wr && (bus.address == 3'd5);

    // Edge detect on the synchronized copy; disable gates events only,
    // LIVE keeps tracking.
    assign rise     = s2 & ~s3 & {WIDTH{enable_q}};
    assign edge_clr = wr_edge ? bus.writedata[WIDTH-1:0] : '0;

    // Lowest set bit of rise wins: scan from the top so lower bits overwrite.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rise[i]) low_idx = 5'(i);
        end
    end

    // Counter: a clear and an event in the same cycle leaves exactly one count.
    always_comb begin
        count_d = wr_count ? '0 : count_q;
        if (|rise && (count_d != CNT_MAX)) count_d = count_d + CNT_W'(1);
    end

    // FIRST capture FSM: re-arm is applied before the capture test so a
    // re-arm coinciding with an event captures the new index.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        if (wr_first) state_d = ARMED;
        if ((state_d == ARMED) && |rise) begin
            state_d = CAPTURED;
            index_d = low_idx;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = 32'(s2);
            3'd1:    rd_mux = 32'(edge_q);
            3'd2:    rd_mux = 32'(mask_q);
            3'd3:    rd_mux = 32'(count_q);
            3'd4:    rd_mux = {(state_q == CAPTURED), 26'b0, index_q};
            3'd5:    rd_mux = {31'b0, enable_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1           <= '0;
            s2           <= '0;
            s3           <= '0;
            edge_q       <= '0;
            mask_q       <= '0;
            enable_q     <= 1'b1;
            count_q      <= '0;
            state_q      <= ARMED;
            index_q      <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, so the s1->s2->s3 chain shifts by one stage.
            s1           <= in_port;
            s2           <= s1;
            s3           <= s2;
            // Set beats clear when both hit the same bit in one cycle.
            edge_q       <= (edge_q & ~edge_clr) | rise;
            if (wr_mask) mask_q   <= bus.writedata[WIDTH-1:0];
            if (wr_ctrl) enable_q <= bus.writedata[0];
            count_q      <= count_d;
            state_q      <= state_d;
            index_q      <= index_d;
            irq          <= |(edge_q & mask_q);
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_q_sys_dig_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_q_sys_dig_error_monitor
// Self-checking bench: expected read values are queued when a read is issued
// and compared when readdata returns one cycle later. A second instance with a
// 3-bit counter shares the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_q_sys_dig_error_monitor;

    localparam int WIDTH = 20;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] exp_sat;
    } sb_entry_t;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    logic             irq;
    logic             irq_sat;

    int n_vec = 0;
    int n_err = 0;
    sb_entry_t sb_q[$];

    q_sys_dig_error_monitor_if bus ();
    q_sys_dig_error_monitor_if bus_sat ();

    assign bus_sat.address    = bus.address;
    assign bus_sat.chipselect = bus.chipselect;
    assign bus_sat.write_n    = bus.write_n;
    assign bus_sat.writedata  = bus.writedata;

    q_sys_dig_error_monitor #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    q_sys_dig_error_monitor #(.WIDTH(WIDTH), .CNT_W(3)) dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_sat.slave),
        .in_port (in_port),
        .irq     (irq_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    // Read both instances; exp_sat is the expectation for the 3-bit counter copy.
    task automatic read2(input logic [2:0] a, input logic [31:0] exp,
                         input logic [31:0] exp_sat, input string tag);
        sb_entry_t e;
        sb_q.push_back('{tag, exp, exp_sat});
        bus.address    = a;
        bus.chipselect = 1'b1;
        tick(1);
        e = sb_q.pop_front();
        check(e.tag, bus.readdata, e.exp);
        check({e.tag, "_sat"}, bus_sat.readdata, e.exp_sat);
        bus.chipselect = 1'b0;
    endtask

    task automatic read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        read2(a, exp, exp, tag);
    endtask

    task automatic pulse(input int bit_i);
        in_port[bit_i] = 1'b1;
        tick(2);
        in_port[bit_i] = 1'b0;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        in_port        = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(3);
        reset_n = 1'b1;

        // 1. Reset state
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        read(3'd0, 32'h0, "rst_live");
        read(3'd4, 32'h0, "rst_first");
        read(3'd5, 32'h1, "rst_ctrl");
        read(3'd3, 32'h0, "rst_count");

        // 2. First event: bits 4 and 10 together
        in_port = 20'h00410;
        tick(3);
        read(3'd0, 32'h00410, "t2_live");
        read(3'd1, 32'h00410, "t2_edge");
        read(3'd3, 32'h1, "t2_count");
        read(3'd4, 32'h80000004, "t2_first");
        check("t2_irq_masked", {31'b0, irq}, 32'h0);

        // 3. Mask and W1C clear drive irq with one cycle of latency
        bus_write(3'd2, 32'h00010);
        check("t3_irq_lat", {31'b0, irq}, 32'h0);
        tick(1);
        check("t3_irq_on", {31'b0, irq}, 32'h1);
        bus_write(3'd1, 32'h00010);
        check("t3_irq_hold", {31'b0, irq}, 32'h1);
        tick(1);
        check("t3_irq_off", {31'b0, irq}, 32'h0);
        read(3'd1, 32'h00400, "t3_edge");

        // 4. Twenty pulses on bit 7, then re-arm and catch bit 19
        bus_write(3'd3, 32'h0);
        for (int i = 0; i < 20; i++) pulse(7);
        read2(3'd3, 32'd20, 32'd7, "t4_count20");
        read(3'd4, 32'h80000004, "t4_first_hold");
        bus_write(3'd4, 32'h0);
        pulse(19);
        read(3'd4, 32'h80000013, "t4_first19");
        read2(3'd3, 32'd21, 32'd7, "t4_count21");
        read(3'd1, 32'h80480, "t4_edge");

        // 5. Same-cycle set beats clear; clear plus event leaves COUNT=1
        bus_write(3'd1, 32'h00080);
        read(3'd1, 32'h80400, "t5_edge_clr");
        in_port[7] = 1'b1;
        tick(2);
        bus_write(3'd1, 32'h00080);
        tick(1);
        read(3'd1, 32'h80480, "t5_set_wins");
        in_port[7] = 1'b0;
        tick(2);
        bus_write(3'd1, 32'h00080);
        in_port[7] = 1'b1;
        tick(2);
        bus_write(3'd3, 32'h0);
        in_port[7] = 1'b0;
        tick(3);
        read(3'd3, 32'h1, "t5_count_clr_evt");

        // 6. Disabled: LIVE follows, event state frozen
        bus_write(3'd5, 32'h0);
        read(3'd5, 32'h0, "t6_ctrl");
        in_port = 20'h00414;
        tick(3);
        pulse(12);
        read(3'd0, 32'h00414, "t6_live");
        read(3'd1, 32'h80480, "t6_edge");
        read(3'd3, 32'h1, "t6_count");
        read(3'd4, 32'h80000013, "t6_first");

        // Reset mid-run with irq active and bits held high on in_port
        bus_write(3'd2, 32'h00400);
        tick(1);
        check("t6_irq_pre", {31'b0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_readdata", bus.readdata, 32'h0);
        check("t6_rst_irq", {31'b0, irq}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        read(3'd5, 32'h1, "t6_ctrl_rst");
        read(3'd2, 32'h0, "t6_mask_rst");
        read(3'd1, 32'h0, "t6_edge_pre");
        read(3'd1, 32'h00414, "t6_edge_post");
        read(3'd4, 32'h80000002, "t6_first_post");
        read(3'd3, 32'h1, "t6_count_post");
        read(3'd0, 32'h00414, "t6_live_post");
        read(3'd6, 32'h0, "t6_addr6");
        read(3'd7, 32'h0, "t6_addr7");
        check("t6_irq_post", {31'b0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
